// File: rtl/mem_arbiter.sv
// Two-way round-robin arbiter sharing single-ported main memory between the
// i-cache (line refill) and the d-cache (line refill or write-back).
module mem_arbiter #(
   parameter int ADDR_WIDTH      = 17,
   parameter int LEN             = 32,
   parameter int LINE_WORDS      = 4,
   parameter int LINE_INDEX_SIZE = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_req,
   input  logic [ADDR_WIDTH-1:0]      i_addr,
   output logic [LEN*LINE_WORDS-1:0]  i_line,
   output logic                       i_done,
   input  logic                       d_req,
   input  logic                       d_we,
   input  logic [ADDR_WIDTH-1:0]      d_addr,
   input  logic [LEN*LINE_WORDS-1:0]  d_wline,
   output logic [LEN*LINE_WORDS-1:0]  d_rline,
   output logic                       d_done,
   output logic                       mem_en,
   output logic                       mem_wr,
   output logic [ADDR_WIDTH-1:0]      mem_addr,
   output logic [LEN-1:0]             mem_wdata,
   input  logic [LEN-1:0]             mem_rdata,
   output logic                       busy,
   output logic                       grant_owner
);

   localparam int CW      = LINE_INDEX_SIZE + 1;
   localparam int LBITS   = LEN * LINE_WORDS;
   localparam logic [ADDR_WIDTH-1:0] BASE_MASK =
      ~(ADDR_WIDTH'((1 << (LINE_INDEX_SIZE + 2)) - 1));

   typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} state_t;

   state_t                     state, state_next;
   logic [CW-1:0]              issue_cnt;
   logic                       owner;
   logic                       last_owner;
   logic                       we;
   logic [ADDR_WIDTH-1:0]      base;
   logic [LBITS-1:0]           wline;
   logic [LBITS-1:0]           rbuf;
   logic [LBITS-1:0]           full_line;
   logic                       grant_d;
   logic                       last_issue;
   logic [LINE_INDEX_SIZE-1:0] word_idx;
   logic [LINE_INDEX_SIZE-1:0] slot;

   // The counter is one bit wider than a word index so it reaches LINE_WORDS
   // in DRAIN, letting the last word land in slot LINE_WORDS-1.
   assign word_idx   = issue_cnt[LINE_INDEX_SIZE-1:0];
   assign slot       = word_idx - LINE_INDEX_SIZE'(1);
   assign last_issue = (issue_cnt == CW'(LINE_WORDS - 1));

   assign mem_addr    = base + (ADDR_WIDTH'(issue_cnt) << 2);
   assign busy        = (state != IDLE);
   assign grant_owner = owner;

   // On a tie the requester that did not own the previous grant wins.
   always_comb begin
      grant_d = d_req;
      if (i_req && d_req) begin
         grant_d = ~last_owner;
      end
   end

   always_comb begin
      full_line = rbuf;
      full_line[(LINE_WORDS-1)*LEN +: LEN] = mem_rdata;
   end

   always_comb begin
      state_next = state;
      mem_en     = 1'b0;
      mem_wr     = 1'b0;
      mem_wdata  = '0;
      i_done     = 1'b0;
      d_done     = 1'b0;
      case (state)
         IDLE: begin
            if (i_req || d_req) begin
               state_next = (grant_d && d_we) ? WRITE : READ;
            end
         end
         READ: begin
            mem_en = 1'b1;
            if (last_issue) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            state_next = DONE;
         end
         WRITE: begin
            mem_en    = 1'b1;
            mem_wr    = 1'b1;
            mem_wdata = wline[word_idx*LEN +: LEN];
            if (last_issue) begin
               state_next = DONE;
            end
         end
         DONE: begin
            i_done     = ~owner;
            d_done     = owner;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Read data trails its strobe by a cycle, so slot k fills while word k+1
   // is being issued; the owner's line is published whole on the DRAIN edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         issue_cnt  <= '0;
         owner      <= 1'b0;
         last_owner <= 1'b0;
         we         <= 1'b0;
         base       <= '0;
         wline      <= '0;
         rbuf       <= '0;
         i_line     <= '0;
         d_rline    <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (i_req || d_req) begin
                  owner     <= grant_d;
                  we        <= grant_d & d_we;
                  base      <= (grant_d ? d_addr : i_addr) & BASE_MASK;
                  wline     <= d_wline;
                  issue_cnt <= '0;
               end
            end
            READ: begin
               issue_cnt <= issue_cnt + CW'(1);
               if (issue_cnt != '0) begin
                  rbuf[slot*LEN +: LEN] <= mem_rdata;
               end
            end
            DRAIN: begin
               if (owner) begin
                  d_rline <= full_line;
               end else begin
                  i_line <= full_line;
               end
            end
            WRITE: begin
               issue_cnt <= issue_cnt + CW'(1);
            end
            DONE: begin
               last_owner <= owner;
            end
            default: begin
            end
         endcase
      end
   end

   logic unused_we;
   assign unused_we = we;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, tie/reset
// sequences and randomized traffic against a word-level memory model.
module tb_mem_arbiter;

   localparam int AW  = 17;
   localparam int LEN = 32;
   localparam int LW  = 4;
   localparam int NW  = 1 << (AW - 2);

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              i_req = 1'b0;
   logic [AW-1:0]     i_addr = '0;
   logic [LEN*LW-1:0] i_line;
   logic              i_done;
   logic              d_req = 1'b0;
   logic              d_we = 1'b0;
   logic [AW-1:0]     d_addr = '0;
   logic [LEN*LW-1:0] d_wline = '0;
   logic [LEN*LW-1:0] d_rline;
   logic              d_done;
   logic              mem_en;
   logic              mem_wr;
   logic [AW-1:0]     mem_addr;
   logic [LEN-1:0]    mem_wdata;
   logic [LEN-1:0]    mem_rdata = '0;
   logic              busy;
   logic              grant_owner;

   mem_arbiter #(.ADDR_WIDTH(AW), .LEN(LEN), .LINE_WORDS(LW), .LINE_INDEX_SIZE(2)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_line(i_line), .i_done(i_done),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wline(d_wline),
      .d_rline(d_rline), .d_done(d_done),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy), .grant_owner(grant_owner)
   );

   always #5 clk = ~clk;

   // Main RAM seen by the DUT, and the bench's own expectation of its contents.
   logic [LEN-1:0] ram    [0:NW-1];
   logic [LEN-1:0] shadow [0:NW-1];

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_wr) ram[mem_addr[AW-1:2]] <= mem_wdata;
         else        mem_rdata <= ram[mem_addr[AW-1:2]];
      end
   end

   int checks = 0;
   int errors = 0;
   logic [LEN*LW-1:0] expILine = '0;
   logic [LEN*LW-1:0] expDLine = '0;

   typedef struct {
      bit            isD;
      bit            wr;
      logic [AW-1:0] addr;
      logic [127:0]  wline;
      bit            chkLine;
      logic [127:0]  expLine;
      logic [AW-1:0] expBase;
   } vec_t;

   vec_t vecs [6];

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int wordAt(input int base, input int k);
      return ((base + 4 * k) % (1 << AW)) / 4;
   endfunction

   function automatic logic [127:0] modelLine(input int base);
      logic [127:0] l;
      for (int k = 0; k < LW; k++) l[k*LEN +: LEN] = shadow[wordAt(base, k)];
      return l;
   endfunction

   task automatic modelWrite(input int base, input logic [127:0] wl);
      for (int k = 0; k < LW; k++) shadow[wordAt(base, k)] = wl[k*LEN +: LEN];
   endtask

   // One complete transaction with per-cycle checks of strobes, timing and lines.
   task automatic applyStimulus(input bit isD, input bit wr, input logic [AW-1:0] addr,
                                input logic [127:0] wl, input bit chkLine,
                                input logic [127:0] expLine, input logic [AW-1:0] expBase);
      int k = 0;
      int nStrobe = 0;
      int doneAt = -1;
      int base = int'(addr) / 16 * 16;
      @(negedge clk);
      if (isD) begin
         d_req = 1'b1; d_we = wr; d_addr = addr; d_wline = wl;
      end else begin
         i_req = 1'b1; i_addr = addr;
      end
      while (doneAt < 0 && k < 20) begin
         @(negedge clk);
         k++;
         if (mem_en) begin
            checkOutput("strobeAddr", 128'(mem_addr), 128'((int'(expBase) + 4 * nStrobe) % (1 << AW)));
            checkOutput("strobeCycle", 128'(k), 128'(nStrobe + 1));
            checkOutput("strobeWr", 128'(mem_wr), 128'(wr));
            if (wr) checkOutput("strobeWdata", 128'(mem_wdata), 128'(wl[nStrobe*LEN +: LEN]));
            nStrobe++;
         end
         if (busy) checkOutput("grantOwner", 128'(grant_owner), 128'(isD));
         checkOutput("otherDone", 128'(isD ? i_done : d_done), 128'(0));
         if (isD ? d_done : i_done) doneAt = k;
      end
      checkOutput("doneCycle", 128'(doneAt), 128'(wr ? LW + 1 : LW + 2));
      checkOutput("strobeCount", 128'(nStrobe), 128'(LW));
      if (wr) begin
         modelWrite(base, wl);
      end else begin
         if (isD) expDLine = modelLine(base);
         else     expILine = modelLine(base);
         if (chkLine) checkOutput("tableLine", isD ? d_rline : i_line, expLine);
      end
      checkOutput("iLine", i_line, expILine);
      checkOutput("dRline", d_rline, expDLine);
      i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      @(negedge clk);
      checkOutput("idleAfterDone", 128'({busy, i_done, d_done}), 128'(0));
   endtask

   // Both caches request together; d-cache must win, i-cache follows after one IDLE.
   task automatic tieSequence(input bit dWr, input logic [AW-1:0] dA,
                              input logic [AW-1:0] iA, input logic [127:0] wl);
      int k = 0;
      int iAt = -1;
      int dAt = -1;
      @(negedge clk);
      i_req = 1'b1; i_addr = iA;
      d_req = 1'b1; d_we = dWr; d_addr = dA; d_wline = wl;
      while ((iAt < 0 || dAt < 0) && k < 40) begin
         @(negedge clk);
         k++;
         if (d_done) begin
            dAt = k;
            d_req = 1'b0; d_we = 1'b0;
            if (dWr) modelWrite(int'(dA) / 16 * 16, wl);
            else     expDLine = modelLine(int'(dA) / 16 * 16);
            checkOutput("tieDRline", d_rline, expDLine);
         end
         if (i_done) begin
            iAt = k;
            i_req = 1'b0;
            expILine = modelLine(int'(iA) / 16 * 16);
            checkOutput("tieILine", i_line, expILine);
         end
      end
      checkOutput("tieDDone", 128'(dAt), 128'(dWr ? LW + 1 : LW + 2));
      checkOutput("tieIDone", 128'(iAt), 128'((dWr ? LW + 1 : LW + 2) + 1 + LW + 2));
      @(negedge clk);
   endtask

   initial begin
      bit sawDone;
      for (int w = 0; w < NW; w++) begin
         ram[w]    = 32'hC0DE0000 ^ w;
         shadow[w] = 32'hC0DE0000 ^ w;
      end
      for (int w = 0; w < LW; w++) begin
         ram[4 + w]    = 32'hA0 + w;
         shadow[4 + w] = 32'hA0 + w;
      end

      vecs[0] = '{1'b0, 1'b0, 17'h00010, 128'h0, 1'b1,
                  128'h000000A3_000000A2_000000A1_000000A0, 17'h00010};
      vecs[1] = '{1'b1, 1'b1, 17'h0002C, 128'h00000044_00000033_00000022_00000011,
                  1'b0, 128'h0, 17'h00020};
      vecs[2] = '{1'b1, 1'b0, 17'h00024, 128'h0, 1'b1,
                  128'h00000044_00000033_00000022_00000011, 17'h00020};
      vecs[3] = '{1'b1, 1'b1, 17'h1FFF0, 128'hDEAD0004_DEAD0003_DEAD0002_DEAD0001,
                  1'b0, 128'h0, 17'h1FFF0};
      vecs[4] = '{1'b0, 1'b0, 17'h1FFFF, 128'h0, 1'b1,
                  128'hDEAD0004_DEAD0003_DEAD0002_DEAD0001, 17'h1FFF0};
      vecs[5] = '{1'b0, 1'b0, 17'h00013, 128'h0, 1'b1,
                  128'h000000A3_000000A2_000000A1_000000A0, 17'h00010};

      repeat (2) @(negedge clk);
      checkOutput("resetMem", 128'({mem_en, mem_wr, mem_addr, mem_wdata}), 128'(0));
      checkOutput("resetCtl", 128'({i_done, d_done, busy, grant_owner}), 128'(0));
      checkOutput("resetILine", i_line, 128'(0));
      checkOutput("resetDRline", d_rline, 128'(0));
      rst = 1'b0;

      tieSequence(1'b0, 17'h00100, 17'h00200, 128'h0);
      tieSequence(1'b1, 17'h00300, 17'h00304, 128'h13579BDF_2468ACE0_0F0F0F0F_CAFEF00D);

      for (int v = 0; v < 6; v++) begin
         applyStimulus(vecs[v].isD, vecs[v].wr, vecs[v].addr, vecs[v].wline,
                       vecs[v].chkLine, vecs[v].expLine, vecs[v].expBase);
      end

      for (int r = 0; r < 30; r++) begin
         bit isD = 1'($urandom_range(0, 1));
         bit wr = isD & 1'($urandom_range(0, 1));
         logic [AW-1:0] a = AW'($urandom_range(0, (1 << AW) - 1));
         logic [127:0] wl = {$urandom, $urandom, $urandom, $urandom};
         repeat ($urandom_range(0, 2)) @(negedge clk);
         applyStimulus(isD, wr, a, wl, 1'b0, 128'h0, AW'(int'(a) / 16 * 16));
      end

      // Reset three cycles into an i-cache read aborts it without a done pulse.
      @(negedge clk);
      i_req = 1'b1; i_addr = 17'h00040;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("abortBusy", 128'(busy), 128'(0));
      checkOutput("abortMemEn", 128'(mem_en), 128'(0));
      checkOutput("abortILine", i_line, 128'(0));
      checkOutput("abortDRline", d_rline, 128'(0));
      rst = 1'b0; i_req = 1'b0;
      expILine = '0; expDLine = '0;
      sawDone = i_done;
      repeat (8) begin
         @(negedge clk);
         sawDone |= i_done;
      end
      checkOutput("abortNoDone", 128'(sawDone), 128'(0));
      applyStimulus(1'b0, 1'b0, 17'h00018, 128'h0, 1'b1,
                    128'h000000A3_000000A2_000000A1_000000A0, 17'h00010);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
